prv_trap_ctrl: RTL and testbench
================================

Name: prv_trap_ctrl

Overview:
- Privilege-side responder for the hazard-unit exception/interrupt handshake, machine mode only.
- Collects exception flags and return requests from the pipeline, together with the interrupt pending and enable state.
- Prioritises them and waits for the pipeline to drain (pipe_clear).
- Then issues a one-cycle PC redirect (insert_pc/priv_pc) together with the matching mepc/mcause/mtval/mstatus write strobes toward the CSR file.
- Also owns WFI sleep sequencing.

Parameters:
- XLEN, 32, datapath width for PCs, addresses and CSR values.
- VECTORED_EN, 1, when 1, honour mtvec.MODE=1 (vectored) for interrupts; when 0, always use direct mode.

Ports:
- CLK  in  1  clock
- RST  in  1  asynchronous active-high reset
- fault_insn, mal_insn, illegal_insn, fault_l, mal_l, fault_s, mal_s, breakpoint, env  in  1 each  exception flags from hazard unit
- fault_insn_page, fault_load_page, fault_store_page  in  1 each  page-fault flags from the TLBs
- mret  in  1  return request
- wfi  in  1  WFI instruction reached commit
- pipe_clear  in  1  pipeline drained, safe to redirect
- epc  in  XLEN  PC of the committing/faulting instruction
- badaddr  in  XLEN  faulting address or instruction bits
- timer_int, soft_int, ext_int  in  1 each  pending interrupt lines
- mie_reg  in  XLEN  mie CSR (bits 3, 7, 11 used)
- mstatus_mie  in  1  global interrupt enable
- mtvec  in  XLEN  trap vector CSR
- mepc_r  in  XLEN  current mepc
- insert_pc  out  1  one-cycle redirect strobe
- priv_pc  out  XLEN  redirect target
- intr  out  1  an interrupt or exception is pending or being serviced
- wfi_stall  out  1  hold fetch while sleeping
- mepc_we, mcause_we, mtval_we  out  1 each  CSR write strobes
- mepc_next, mcause_next, mtval_next  out  XLEN  CSR write data
- mstatus_trap, mstatus_ret  out  1 each  trap: MPIE<-MIE, MIE<-0; ret: MIE<-MPIE, MPIE<-1

Behaviour:
- Reset:
  - State is IDLE.
  - All outputs are 0; priv_pc is 0.
  - Asserting RST in any state returns to IDLE next edge and drops every strobe immediately.
- States: IDLE, WAIT_CLEAR, REDIRECT, SLEEP.
- Interrupt recognition:
  - pend = {ext_int & mie_reg[11], soft_int & mie_reg[3], timer_int & mie_reg[7]}.
  - take_int = mstatus_mie & |pend.
  - Priority is ext (cause 11) > soft (3) > timer (7).
  - mcause bit XLEN-1 = 1 for interrupts.
- Exception priority, highest first, with cause in brackets:
  - breakpoint(3), fault_insn_page(12), fault_insn(1), mal_insn(0), illegal_insn(2), env(11), mal_s(6), mal_l(4), fault_store_page(15), fault_load_page(13), fault_s(7), fault_l(5).
- Interrupts beat exceptions; an exception beats mret.
- IDLE transitions:
  - On any exception, take_int or mret: latch cause, epc, badaddr and kind {INT, EXC, RET}, then go to WAIT_CLEAR.
  - Else, on wfi: go to SLEEP.
  - intr = 1 from the latch cycle through REDIRECT.
- WAIT_CLEAR:
  - The latched event is frozen; new flags are ignored.
  - When pipe_clear = 1, go to REDIRECT.
  - If pipe_clear is already 1 in the latch cycle, skip directly to REDIRECT (latency 1 cycle from flag to insert_pc).
- REDIRECT (exactly one cycle, then IDLE):
  - insert_pc = 1.
  - For EXC/INT:
    - mepc_we = mcause_we = mtval_we = mstatus_trap = 1.
    - mepc_next = {epc[XLEN-1:2], 2'b00}.
    - mtval_next = badaddr for EXC, 0 for INT.
    - priv_pc = {mtvec[XLEN-1:2], 2'b00} + (VECTORED_EN & mtvec[1:0]==1 & INT ? cause<<2 : 0).
    - Add modulo 2^XLEN, wrap-around allowed.
  - For RET: mstatus_ret = 1, priv_pc = mepc_r, no other CSR writes.
- SLEEP:
  - wfi_stall = 1.
  - Exit to IDLE when |pend (ignoring mstatus_mie).
  - If take_int, the interrupt is latched in the exit cycle itself, as in IDLE.
- mtvec[1:0]=2 or 3 is treated as direct mode.

Decomposition:
- priv_isa_types_pkg holds:
  - the cause-code enum (exception and interrupt);
  - the FSM state enum;
  - the kind enum {INT, EXC, RET};
  - the mie bit-index constants.
- One natural sub-module: prv_trap_prio, purely combinational.
  - Inputs: flags and pend.
  - Outputs: valid, is_int and cause.

Test Plan:
- illegal_insn=1, epc=0x0000_0104, badaddr=0x0000_0073, pipe_clear=1, mtvec=0x8000_0000 -> next cycle insert_pc=1, priv_pc=0x8000_0000, mcause_next=2, mepc_next=0x104, mtval_next=0x73, mstatus_trap=1, one cycle only.
- ext_int=1, mie_reg[11]=1, mstatus_mie=1, mtvec=0x8000_0001, pipe_clear low 3 cycles -> insert_pc 1 cycle after pipe_clear rises, priv_pc=0x8000_002C, mcause_next=0x8000_000B, mtval_next=0.
- mret with mepc_r=0x0000_2000 and a simultaneous fault_l -> exception wins: mcause_next=5, priv_pc=mtvec base; mret-only repeat -> priv_pc=0x2000, mstatus_ret=1, mepc_we=0.
- timer_int and breakpoint together, both enabled -> mcause_next=0x8000_0007; with mstatus_mie=0 -> mcause_next=3.
- wfi, then timer_int=1 after 5 cycles with mstatus_mie=0 -> wfi_stall high 5 cycles, return to IDLE, no insert_pc.
- RST asserted in WAIT_CLEAR -> all outputs 0 asynchronously; a post-reset pipe_clear produces no redirect.

Source files
------------

// File: rtl/priv_isa_types_pkg.sv
// Shared types for the machine-mode trap controller: cause codes, FSM states,
// event kinds and mie bit positions.
package priv_isa_types_pkg;

    typedef enum logic [4:0] {
        ExcInsnMisaligned  = 5'd0,
        ExcInsnFault       = 5'd1,
        ExcIllegalInsn     = 5'd2,
        ExcBreakpoint      = 5'd3,
        ExcLoadMisaligned  = 5'd4,
        ExcLoadFault       = 5'd5,
        ExcStoreMisaligned = 5'd6,
        ExcStoreFault      = 5'd7,
        ExcEcallM          = 5'd11,
        ExcInsnPageFault   = 5'd12,
        ExcLoadPageFault   = 5'd13,
        ExcStorePageFault  = 5'd15
    } exc_cause_e;

    typedef enum logic [4:0] {
        IntSoft  = 5'd3,
        IntTimer = 5'd7,
        IntExt   = 5'd11
    } int_cause_e;

    typedef enum logic [1:0] {
        StIdle,
        StWaitClear,
        StRedirect,
        StSleep
    } state_e;

    typedef enum logic [1:0] {
        KindInt,
        KindExc,
        KindRet
    } kind_e;

    localparam int unsigned MieMsie = 3;
    localparam int unsigned MieMtie = 7;
    localparam int unsigned MieMeie = 11;

    typedef struct packed {
        logic fault_insn;
        logic mal_insn;
        logic illegal_insn;
        logic fault_l;
        logic mal_l;
        logic fault_s;
        logic mal_s;
        logic breakpoint;
        logic env;
        logic fault_insn_page;
        logic fault_load_page;
        logic fault_store_page;
    } exc_flags_t;

endpackage

// File: rtl/prv_trap_prio.sv
// Combinational trap arbiter: enabled interrupts first (ext > soft > timer),
// then exceptions in fixed priority order.
module prv_trap_prio
    import priv_isa_types_pkg::*;
(
    input  exc_flags_t  flags,
    input  logic [2:0]  pend,
    output logic        valid,
    output logic        is_int,
    output logic [4:0]  cause
);

    always_comb begin
        valid  = 1'b1;
        is_int = 1'b0;
        cause  = 5'd0;
        if (pend[2]) begin
            is_int = 1'b1;
            cause  = IntExt;
        end else if (pend[1]) begin
            is_int = 1'b1;
            cause  = IntSoft;
        end else if (pend[0]) begin
            is_int = 1'b1;
            cause  = IntTimer;
        end else if (flags.breakpoint) begin
            cause = ExcBreakpoint;
        end else if (flags.fault_insn_page) begin
            cause = ExcInsnPageFault;
        end else if (flags.fault_insn) begin
            cause = ExcInsnFault;
        end else if (flags.mal_insn) begin
            cause = ExcInsnMisaligned;
        end else if (flags.illegal_insn) begin
            cause = ExcIllegalInsn;
        end else if (flags.env) begin
            cause = ExcEcallM;
        end else if (flags.mal_s) begin
            cause = ExcStoreMisaligned;
        end else if (flags.mal_l) begin
            cause = ExcLoadMisaligned;
        end else if (flags.fault_store_page) begin
            cause = ExcStorePageFault;
        end else if (flags.fault_load_page) begin
            cause = ExcLoadPageFault;
        end else if (flags.fault_s) begin
            cause = ExcStoreFault;
        end else if (flags.fault_l) begin
            cause = ExcLoadFault;
        end else begin
            valid = 1'b0;
        end
    end

endmodule

// File: rtl/prv_trap_ctrl.sv
// Machine-mode trap/return/WFI sequencer: latches the winning event, waits for
// the pipeline to drain, then issues a one-cycle redirect with CSR updates.
module prv_trap_ctrl
    import priv_isa_types_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter bit          VECTORED_EN = 1'b1
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            fault_insn,
    input  logic            mal_insn,
    input  logic            illegal_insn,
    input  logic            fault_l,
    input  logic            mal_l,
    input  logic            fault_s,
    input  logic            mal_s,
    input  logic            breakpoint,
    input  logic            env,
    input  logic            fault_insn_page,
    input  logic            fault_load_page,
    input  logic            fault_store_page,
    input  logic            mret,
    input  logic            wfi,
    input  logic            pipe_clear,
    input  logic [XLEN-1:0] epc,
    input  logic [XLEN-1:0] badaddr,
    input  logic            timer_int,
    input  logic            soft_int,
    input  logic            ext_int,
    input  logic [XLEN-1:0] mie_reg,
    input  logic            mstatus_mie,
    input  logic [XLEN-1:0] mtvec,
    input  logic [XLEN-1:0] mepc_r,
    output logic            insert_pc,
    output logic [XLEN-1:0] priv_pc,
    output logic            intr,
    output logic            wfi_stall,
    output logic            mepc_we,
    output logic            mcause_we,
    output logic            mtval_we,
    output logic [XLEN-1:0] mepc_next,
    output logic [XLEN-1:0] mcause_next,
    output logic [XLEN-1:0] mtval_next,
    output logic            mstatus_trap,
    output logic            mstatus_ret
);

    state_e          state_q, state_d;
    kind_e           kind_q, kind_d;
    logic [4:0]      cause_q;
    logic [XLEN-3:0] epc_q;
    logic [XLEN-1:0] badaddr_q;

    logic [2:0]  pend;
    logic [2:0]  int_pend;
    logic        take_int;
    exc_flags_t  flags, flags_sel;
    logic        prio_valid, prio_is_int;
    logic [4:0]  prio_cause;
    logic        latch;

    logic unused_bits;
    assign unused_bits = ^{mie_reg, epc[1:0]};

    assign pend     = {ext_int & mie_reg[MieMeie], soft_int & mie_reg[MieMsie],
                       timer_int & mie_reg[MieMtie]};
    assign take_int = mstatus_mie & (|pend);
    assign int_pend = mstatus_mie ? pend : 3'b000;

    assign flags = '{
        fault_insn:       fault_insn,
        mal_insn:         mal_insn,
        illegal_insn:     illegal_insn,
        fault_l:          fault_l,
        mal_l:            mal_l,
        fault_s:          fault_s,
        mal_s:            mal_s,
        breakpoint:       breakpoint,
        env:              env,
        fault_insn_page:  fault_insn_page,
        fault_load_page:  fault_load_page,
        fault_store_page: fault_store_page
    };

    // While sleeping only interrupts can wake and be taken.
    assign flags_sel = (state_q == StSleep) ? '0 : flags;

    prv_trap_prio u_prio (
        .flags  (flags_sel),
        .pend   (int_pend),
        .valid  (prio_valid),
        .is_int (prio_is_int),
        .cause  (prio_cause)
    );

    always_comb begin
        latch = 1'b0;
        if (!RST) begin
            if (state_q == StIdle)  latch = prio_valid | mret;
            if (state_q == StSleep) latch = prio_valid;
        end
    end

    always_comb begin
        if (prio_is_int)     kind_d = KindInt;
        else if (prio_valid) kind_d = KindExc;
        else                 kind_d = KindRet;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            kind_q    <= KindInt;
            cause_q   <= 5'd0;
            epc_q     <= '0;
            badaddr_q <= '0;
        end else if (latch) begin
            kind_q    <= kind_d;
            cause_q   <= prio_valid ? prio_cause : 5'd0;
            epc_q     <= epc[XLEN-1:2];
            badaddr_q <= badaddr;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (latch)    state_d = pipe_clear ? StRedirect : StWaitClear;
                else if (wfi) state_d = StSleep;
            end
            StWaitClear: begin
                if (pipe_clear) state_d = StRedirect;
            end
            StRedirect: state_d = StIdle;
            StSleep: begin
                if (latch)      state_d = pipe_clear ? StRedirect : StWaitClear;
                else if (|pend) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    logic [XLEN-1:0] trap_base;
    logic [XLEN-1:0] vec_off;
    assign trap_base = {mtvec[XLEN-1:2], 2'b00};
    assign vec_off   = (VECTORED_EN && mtvec[1:0] == 2'b01 && kind_q == KindInt) ?
                       {{(XLEN-7){1'b0}}, cause_q, 2'b00} : '0;

    always_comb begin
        insert_pc    = 1'b0;
        priv_pc      = '0;
        mepc_we      = 1'b0;
        mcause_we    = 1'b0;
        mtval_we     = 1'b0;
        mepc_next    = '0;
        mcause_next  = '0;
        mtval_next   = '0;
        mstatus_trap = 1'b0;
        mstatus_ret  = 1'b0;
        wfi_stall    = (state_q == StSleep);
        intr         = latch | (state_q == StWaitClear) | (state_q == StRedirect);
        if (state_q == StRedirect) begin
            insert_pc = 1'b1;
            if (kind_q == KindRet) begin
                mstatus_ret = 1'b1;
                priv_pc     = mepc_r;
            end else begin
                mepc_we      = 1'b1;
                mcause_we    = 1'b1;
                mtval_we     = 1'b1;
                mstatus_trap = 1'b1;
                mepc_next    = {epc_q, 2'b00};
                mcause_next  = {kind_q == KindInt, {(XLEN-6){1'b0}}, cause_q};
                mtval_next   = (kind_q == KindExc) ? badaddr_q : '0;
                priv_pc      = trap_base + vec_off;
            end
        end
    end

endmodule

// File: tb/tb_prv_trap_ctrl.sv
// Directed scoreboard bench for prv_trap_ctrl: the driver queues expected
// redirects, a negedge monitor pops and compares them.
module tb_prv_trap_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic        fault_insn, mal_insn, illegal_insn, fault_l, mal_l, fault_s, mal_s;
    logic        breakpoint, env, fault_insn_page, fault_load_page, fault_store_page;
    logic        mret, wfi, pipe_clear;
    logic [31:0] epc, badaddr, mie_reg, mtvec, mepc_r;
    logic        timer_int, soft_int, ext_int, mstatus_mie;
    logic        insert_pc, intr, wfi_stall, mepc_we, mcause_we, mtval_we;
    logic        mstatus_trap, mstatus_ret;
    logic [31:0] priv_pc, mepc_next, mcause_next, mtval_next;

    typedef struct {
        int unsigned cyc;
        logic [31:0] pc;
        logic [31:0] cause;
        logic [31:0] mepc;
        logic [31:0] mtval;
        logic        ret;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   stall_cnt = 0;
    int   ins_cnt = 0;
    int   ins_before;
    int   base_cyc;

    prv_trap_ctrl #(.XLEN(32), .VECTORED_EN(1'b1)) dut (
        .CLK(CLK), .RST(RST),
        .fault_insn(fault_insn), .mal_insn(mal_insn), .illegal_insn(illegal_insn),
        .fault_l(fault_l), .mal_l(mal_l), .fault_s(fault_s), .mal_s(mal_s),
        .breakpoint(breakpoint), .env(env), .fault_insn_page(fault_insn_page),
        .fault_load_page(fault_load_page), .fault_store_page(fault_store_page),
        .mret(mret), .wfi(wfi), .pipe_clear(pipe_clear), .epc(epc), .badaddr(badaddr),
        .timer_int(timer_int), .soft_int(soft_int), .ext_int(ext_int),
        .mie_reg(mie_reg), .mstatus_mie(mstatus_mie), .mtvec(mtvec), .mepc_r(mepc_r),
        .insert_pc(insert_pc), .priv_pc(priv_pc), .intr(intr), .wfi_stall(wfi_stall),
        .mepc_we(mepc_we), .mcause_we(mcause_we), .mtval_we(mtval_we),
        .mepc_next(mepc_next), .mcause_next(mcause_next), .mtval_next(mtval_next),
        .mstatus_trap(mstatus_trap), .mstatus_ret(mstatus_ret)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic clear_flags();
        {fault_insn, mal_insn, illegal_insn, fault_l, mal_l, fault_s, mal_s} = '0;
        {breakpoint, env, fault_insn_page, fault_load_page, fault_store_page} = '0;
        {mret, wfi, timer_int, soft_int, ext_int} = '0;
    endtask

    task automatic expect_at(input int unsigned at, input logic [31:0] pc,
                             input logic [31:0] cause, input logic [31:0] mepc,
                             input logic [31:0] mtval, input logic ret);
        exp_t e;
        e.cyc = at; e.pc = pc; e.cause = cause; e.mepc = mepc; e.mtval = mtval; e.ret = ret;
        exp_q.push_back(e);
    endtask

    // Monitor: pops one expectation per redirect and checks it lasts one cycle.
    initial begin
        exp_t e;
        logic check_after;
        check_after = 1'b0;
        forever begin
            @(negedge CLK);
            if (wfi_stall) stall_cnt++;
            if (check_after) begin
                chk("one_cycle_insert", {31'd0, insert_pc}, 32'd0);
                check_after = 1'b0;
            end
            if (insert_pc) begin
                ins_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_redirect: got priv_pc %h expected no redirect",
                             priv_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("latency_cycle", cyc, e.cyc);
                    chk("priv_pc", priv_pc, e.pc);
                    chk("mstatus_ret", {31'd0, mstatus_ret}, {31'd0, e.ret});
                    chk("mstatus_trap", {31'd0, mstatus_trap}, {31'd0, !e.ret});
                    chk("csr_we", {29'd0, mepc_we, mcause_we, mtval_we},
                        e.ret ? 32'd0 : 32'd7);
                    if (!e.ret) begin
                        chk("mcause_next", mcause_next, e.cause);
                        chk("mepc_next", mepc_next, e.mepc);
                        chk("mtval_next", mtval_next, e.mtval);
                    end
                end
                check_after = 1'b1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish within time limit");
        $fatal(1);
    end

    initial begin
        RST = 1'b1;
        clear_flags();
        pipe_clear = 1'b1;
        epc = '0; badaddr = '0; mie_reg = '0; mstatus_mie = 1'b0;
        mtvec = 32'h8000_0000; mepc_r = '0;
        step(2);
        illegal_insn = 1'b1;
        #1;
        chk("reset_strobes", {24'd0, insert_pc, intr, wfi_stall, mepc_we, mcause_we,
            mtval_we, mstatus_trap, mstatus_ret}, 32'd0);
        chk("reset_priv_pc", priv_pc, 32'd0);
        chk("reset_csr_data", mepc_next | mcause_next | mtval_next, 32'd0);
        illegal_insn = 1'b0;
        RST = 1'b0;
        step(2);

        // Illegal instruction with pipe already clear: redirect next cycle.
        illegal_insn = 1'b1; epc = 32'h0000_0104; badaddr = 32'h0000_0073;
        expect_at(cyc + 1, 32'h8000_0000, 32'd2, 32'h0000_0104, 32'h0000_0073, 1'b0);
        #1;
        chk("intr_latch_cycle", {31'd0, intr}, 32'd1);
        step();
        clear_flags();
        step(3);

        // External interrupt, vectored, pipe busy for 3 cycles.
        mtvec = 32'h8000_0001; mie_reg = 32'h0000_0800; mstatus_mie = 1'b1;
        epc = 32'h0000_0206; pipe_clear = 1'b0; ext_int = 1'b1;
        step();
        clear_flags();
        chk("intr_wait_clear", {31'd0, intr}, 32'd1);
        step(2);
        pipe_clear = 1'b1;
        expect_at(cyc + 1, 32'h8000_002C, 32'h8000_000B, 32'h0000_0204, 32'd0, 1'b0);
        step();
        mstatus_mie = 1'b0; mie_reg = '0;
        step(3);

        // mret plus load fault: the exception wins.
        mtvec = 32'h8000_0000; mepc_r = 32'h0000_2000;
        epc = 32'h0000_0300; badaddr = 32'h0000_1234;
        mret = 1'b1; fault_l = 1'b1;
        expect_at(cyc + 1, 32'h8000_0000, 32'd5, 32'h0000_0300, 32'h0000_1234, 1'b0);
        step();
        clear_flags();
        step(3);
        mret = 1'b1;
        expect_at(cyc + 1, 32'h0000_2000, 32'd0, 32'd0, 32'd0, 1'b1);
        step();
        clear_flags();
        step(3);

        // Timer interrupt beats breakpoint; masked globally, breakpoint wins.
        mtvec = 32'h8000_0001; mie_reg = 32'h0000_0080; mstatus_mie = 1'b1;
        epc = 32'h0000_0401; badaddr = 32'h0000_0999;
        timer_int = 1'b1; breakpoint = 1'b1;
        expect_at(cyc + 1, 32'h8000_001C, 32'h8000_0007, 32'h0000_0400, 32'd0, 1'b0);
        step();
        clear_flags();
        step(3);
        mstatus_mie = 1'b0; epc = 32'h0000_0500; badaddr = 32'hDEAD_BEEF;
        timer_int = 1'b1; breakpoint = 1'b1;
        expect_at(cyc + 1, 32'h8000_0000, 32'd3, 32'h0000_0500, 32'hDEAD_BEEF, 1'b0);
        step();
        clear_flags();
        step(3);

        // WFI woken by a globally masked timer: no trap taken.
        mtvec = 32'h8000_0000; ins_before = ins_cnt;
        stall_cnt = 0;
        wfi = 1'b1;
        step();
        wfi = 1'b0;
        chk("wfi_stall_sleep", {31'd0, wfi_stall}, 32'd1);
        step(4);
        timer_int = 1'b1;
        step();
        chk("wfi_stall_woken", {31'd0, wfi_stall}, 32'd0);
        step(2);
        chk("wfi_stall_cycles", stall_cnt, 32'd5);
        chk("wfi_no_redirect", ins_cnt, ins_before);
        clear_flags();
        step(2);

        // WFI woken by an enabled timer: interrupt taken on the exit cycle.
        mstatus_mie = 1'b1; epc = 32'h0000_0600;
        wfi = 1'b1;
        step();
        wfi = 1'b0;
        step(2);
        timer_int = 1'b1;
        expect_at(cyc + 1, 32'h8000_0000, 32'h8000_0007, 32'h0000_0600, 32'd0, 1'b0);
        step();
        clear_flags();
        mstatus_mie = 1'b0; mie_reg = '0;
        step(3);

        // Reset while waiting for pipe_clear discards the pending trap.
        pipe_clear = 1'b0; illegal_insn = 1'b1;
        step();
        clear_flags();
        chk("intr_before_reset", {31'd0, intr}, 32'd1);
        #2;
        RST = 1'b1;
        #1;
        chk("async_reset_outputs", {24'd0, insert_pc, intr, wfi_stall, mepc_we, mcause_we,
            mtval_we, mstatus_trap, mstatus_ret}, 32'd0);
        ins_before = ins_cnt;
        step();
        RST = 1'b0; pipe_clear = 1'b1;
        step(4);
        chk("post_reset_no_redirect", ins_cnt, ins_before);

        base_cyc = cyc;
        while (exp_q.size() != 0 && cyc - base_cyc < 20) step();
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
